// File: rtl/risc_register_file.sv
// 32 x 32-bit RISC-V integer register file with two handshaked read ports
// and one handshaked write port; x0 reads as zero and ignores writes.
module risc_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] reg_rd_addr_a,
    input  logic                  reg_rd_addr_a_valid,
    output logic [DATA_WIDTH-1:0] reg_rd_data_a,
    output logic                  reg_rd_data_a_ack,
    input  logic [ADDR_WIDTH-1:0] reg_rd_addr_b,
    input  logic                  reg_rd_addr_b_valid,
    output logic [DATA_WIDTH-1:0] reg_rd_data_b,
    output logic                  reg_rd_data_b_ack,
    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  reg_wr_valid,
    output logic                  reg_wr_ack
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } port_state_t;

    port_state_t rd_a_state, rd_a_state_next;
    port_state_t rd_b_state, rd_b_state_next;
    port_state_t wr_state,   wr_state_next;

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    logic                  capture_a, capture_b, wr_commit;
    logic [DATA_WIDTH-1:0] read_value_a, read_value_b;

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        rd_a_state_next = rd_a_state;
        rd_b_state_next = rd_b_state;
        wr_state_next   = wr_state;
        capture_a       = 1'b0;
        capture_b       = 1'b0;
        wr_commit       = 1'b0;

        case (rd_a_state)
            IDLE:    if (reg_rd_addr_a_valid) begin
                         capture_a       = 1'b1;
                         rd_a_state_next = ACKED;
                     end
            ACKED:   if (!reg_rd_addr_a_valid) rd_a_state_next = IDLE;
            default: rd_a_state_next = IDLE;
        endcase

        case (rd_b_state)
            IDLE:    if (reg_rd_addr_b_valid) begin
                         capture_b       = 1'b1;
                         rd_b_state_next = ACKED;
                     end
            ACKED:   if (!reg_rd_addr_b_valid) rd_b_state_next = IDLE;
            default: rd_b_state_next = IDLE;
        endcase

        case (wr_state)
            IDLE:    if (reg_wr_valid) begin
                         wr_commit     = 1'b1;
                         wr_state_next = ACKED;
                     end
            ACKED:   if (!reg_wr_valid) wr_state_next = IDLE;
            default: wr_state_next = IDLE;
        endcase
    end

    // Write-first bypass: a read captured on the same edge as a write to the
    // same nonzero index sees the incoming data.
    always_comb begin
        read_value_a = mem[reg_rd_addr_a];
        read_value_b = mem[reg_rd_addr_b];
        if (wr_commit && reg_wr_addr == reg_rd_addr_a) read_value_a = reg_wr_data;
        if (wr_commit && reg_wr_addr == reg_rd_addr_b) read_value_b = reg_wr_data;
        if (reg_rd_addr_a == '0) read_value_a = '0;
        if (reg_rd_addr_b == '0) read_value_b = '0;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_a_state        <= IDLE;
            rd_b_state        <= IDLE;
            wr_state          <= IDLE;
            reg_rd_data_a     <= '0;
            reg_rd_data_b     <= '0;
            reg_rd_data_a_ack <= 1'b0;
            reg_rd_data_b_ack <= 1'b0;
            reg_wr_ack        <= 1'b0;
        end else begin
            rd_a_state        <= rd_a_state_next;
            rd_b_state        <= rd_b_state_next;
            wr_state          <= wr_state_next;
            reg_rd_data_a_ack <= capture_a;
            reg_rd_data_b_ack <= capture_b;
            reg_wr_ack        <= wr_commit;
            if (capture_a) reg_rd_data_a <= read_value_a;
            if (capture_b) reg_rd_data_b <= read_value_b;
        end
    end

    // NOTE: the architectural state must read zero after reset, so the array is
    // cleared here; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wr_commit && reg_wr_addr != '0) begin
            mem[reg_wr_addr] <= reg_wr_data;
        end
    end

endmodule

// File: tb/tb_risc_register_file.sv
// Directed self-checking bench for risc_register_file: handshakes, x0,
// write-first bypass, re-arm rule and reset abort.
module tb_risc_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  reg_rd_addr_a, reg_rd_addr_b, reg_wr_addr;
    logic        reg_rd_addr_a_valid, reg_rd_addr_b_valid, reg_wr_valid;
    logic [31:0] reg_rd_data_a, reg_rd_data_b, reg_wr_data;
    logic        reg_rd_data_a_ack, reg_rd_data_b_ack, reg_wr_ack;

    int n_checks = 0;
    int n_errors = 0;
    int ack_count;

    always #5 clk = ~clk;

    risc_register_file dut (
        .clk                 (clk),
        .reset               (reset),
        .reg_rd_addr_a       (reg_rd_addr_a),
        .reg_rd_addr_a_valid (reg_rd_addr_a_valid),
        .reg_rd_data_a       (reg_rd_data_a),
        .reg_rd_data_a_ack   (reg_rd_data_a_ack),
        .reg_rd_addr_b       (reg_rd_addr_b),
        .reg_rd_addr_b_valid (reg_rd_addr_b_valid),
        .reg_rd_data_b       (reg_rd_data_b),
        .reg_rd_data_b_ack   (reg_rd_data_b_ack),
        .reg_wr_addr         (reg_wr_addr),
        .reg_wr_data         (reg_wr_data),
        .reg_wr_valid        (reg_wr_valid),
        .reg_wr_ack          (reg_wr_ack)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns later, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        reg_wr_addr  = addr;
        reg_wr_data  = data;
        reg_wr_valid = 1'b1;
        tick();
        reg_wr_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        reg_rd_addr_a = '0; reg_rd_addr_b = '0; reg_wr_addr = '0;
        reg_rd_addr_a_valid = 1'b0; reg_rd_addr_b_valid = 1'b0;
        reg_wr_valid = 1'b0; reg_wr_data = '0;
        tick(); tick();
        check("rst_data_a", reg_rd_data_a, 32'h0);
        check("rst_data_b", reg_rd_data_b, 32'h0);
        check("rst_acks", {29'b0, reg_rd_data_a_ack, reg_rd_data_b_ack, reg_wr_ack}, 32'h0);
        reset = 1'b0;
        tick();

        // Simultaneous A/B requests acknowledge on the same cycle.
        reg_rd_addr_a = 5'd5; reg_rd_addr_b = 5'd0;
        reg_rd_addr_a_valid = 1'b1; reg_rd_addr_b_valid = 1'b1;
        tick();
        check("ab_same_cycle_acks", {30'b0, reg_rd_data_a_ack, reg_rd_data_b_ack}, 32'h3);
        check("ab_data_a", reg_rd_data_a, 32'h0);
        check("ab_data_b", reg_rd_data_b, 32'h0);
        tick();
        check("ab_acks_low_held", {30'b0, reg_rd_data_a_ack, reg_rd_data_b_ack}, 32'h0);
        reg_rd_addr_a_valid = 1'b0; reg_rd_addr_b_valid = 1'b0;
        tick();

        // Write then read back.
        reg_wr_addr = 5'd3; reg_wr_data = 32'hDEADBEEF; reg_wr_valid = 1'b1;
        tick();
        check("wr3_ack", {31'b0, reg_wr_ack}, 32'h1);
        tick();
        check("wr3_ack_once", {31'b0, reg_wr_ack}, 32'h0);
        reg_wr_valid = 1'b0;
        tick();
        reg_rd_addr_a = 5'd3; reg_rd_addr_b = 5'd3;
        reg_rd_addr_a_valid = 1'b1; reg_rd_addr_b_valid = 1'b1;
        tick();
        check("rd3_ack_a", {31'b0, reg_rd_data_a_ack}, 32'h1);
        check("rd3_data_a", reg_rd_data_a, 32'hDEADBEEF);
        check("rd3_data_b_same_index", reg_rd_data_b, 32'hDEADBEEF);
        reg_rd_addr_a_valid = 1'b0; reg_rd_addr_b_valid = 1'b0;
        tick();

        // x0 ignores writes but the write is still acknowledged.
        reg_wr_addr = 5'd0; reg_wr_data = 32'hFFFFFFFF; reg_wr_valid = 1'b1;
        tick();
        check("wr0_ack", {31'b0, reg_wr_ack}, 32'h1);
        reg_wr_valid = 1'b0;
        tick();
        reg_rd_addr_b = 5'd0; reg_rd_addr_b_valid = 1'b1;
        tick();
        check("rd0_ack_b", {31'b0, reg_rd_data_b_ack}, 32'h1);
        check("rd0_data_b", reg_rd_data_b, 32'h0);
        reg_rd_addr_b_valid = 1'b0;
        tick();

        // Write-first bypass on a same-edge collision.
        write_reg(5'd7, 32'h11);
        reg_wr_addr = 5'd7; reg_wr_data = 32'h22; reg_wr_valid = 1'b1;
        reg_rd_addr_a = 5'd7; reg_rd_addr_a_valid = 1'b1;
        reg_rd_addr_b = 5'd3; reg_rd_addr_b_valid = 1'b1;
        tick();
        check("bypass_data_a", reg_rd_data_a, 32'h22);
        check("bypass_other_index_b", reg_rd_data_b, 32'hDEADBEEF);
        check("bypass_wr_ack", {31'b0, reg_wr_ack}, 32'h1);
        reg_wr_valid = 1'b0; reg_rd_addr_a_valid = 1'b0; reg_rd_addr_b_valid = 1'b0;
        tick();
        reg_rd_addr_b = 5'd7; reg_rd_addr_b_valid = 1'b1;
        tick();
        check("after_bypass_data_b", reg_rd_data_b, 32'h22);
        reg_rd_addr_b_valid = 1'b0;
        tick();

        // Re-arm: a held valid gets one ack; data holds even if storage changes.
        write_reg(5'd4, 32'h44);
        reg_rd_addr_a = 5'd4; reg_rd_addr_a_valid = 1'b1;
        ack_count = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                reg_wr_addr = 5'd4; reg_wr_data = 32'h99; reg_wr_valid = 1'b1;
            end
            if (i == 3) reg_wr_valid = 1'b0;
            tick();
            ack_count += int'(reg_rd_data_a_ack);
        end
        check("held_valid_ack_count", ack_count, 32'd1);
        check("held_data_a_unchanged", reg_rd_data_a, 32'h44);
        reg_rd_addr_a_valid = 1'b0;
        tick();
        check("gap_data_a_unchanged", reg_rd_data_a, 32'h44);
        reg_rd_addr_a_valid = 1'b1;
        tick();
        check("rearm_ack_a", {31'b0, reg_rd_data_a_ack}, 32'h1);
        check("rearm_data_a", reg_rd_data_a, 32'h99);
        reg_rd_addr_a_valid = 1'b0;
        tick();

        // Reset on the same edge as a write request aborts it.
        reg_wr_addr = 5'd9; reg_wr_data = 32'h55; reg_wr_valid = 1'b1;
        reset = 1'b1;
        tick();
        check("rst_abort_no_wr_ack", {31'b0, reg_wr_ack}, 32'h0);
        check("rst_clears_data_a", reg_rd_data_a, 32'h0);
        reset = 1'b0; reg_wr_valid = 1'b0;
        tick();
        reg_rd_addr_a = 5'd9; reg_rd_addr_a_valid = 1'b1;
        reg_rd_addr_b = 5'd3; reg_rd_addr_b_valid = 1'b1;
        tick();
        check("post_rst_ack_a", {31'b0, reg_rd_data_a_ack}, 32'h1);
        check("post_rst_rd9", reg_rd_data_a, 32'h0);
        check("post_rst_rd3_cleared", reg_rd_data_b, 32'h0);
        reg_rd_addr_a_valid = 1'b0; reg_rd_addr_b_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/risc_register_file.md
Name: risc_register_file

Overview:
- 32 x 32-bit integer register file for the RISC-V core, sitting directly downstream of the instruction handler.
- Serves the handler's two operand read ports (A = rs1, B = rs2) with a valid/ack handshake.
- Accepts result writes from the ALU's register output path (rd address plus data) with its own valid/ack handshake.
- x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: register index width.
- NUM_REGS, 32: number of architectural registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- reg_rd_addr_a  input  ADDR_WIDTH  read port A index (rs1).
- reg_rd_addr_a_valid  input  1  port A request, level.
- reg_rd_data_a  output  DATA_WIDTH  port A read data.
- reg_rd_data_a_ack  output  1  port A one-cycle ack pulse.
- reg_rd_addr_b  input  ADDR_WIDTH  read port B index (rs2).
- reg_rd_addr_b_valid  input  1  port B request, level.
- reg_rd_data_b  output  DATA_WIDTH  port B read data.
- reg_rd_data_b_ack  output  1  port B one-cycle ack pulse.
- reg_wr_addr  input  ADDR_WIDTH  write index (rd).
- reg_wr_data  input  DATA_WIDTH  write data.
- reg_wr_valid  input  1  write request, level.
- reg_wr_ack  output  1  write one-cycle ack pulse.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (cycle where reset=1):
  - All registers are cleared to 0.
  - reg_rd_data_a, reg_rd_data_b = 0.
  - All acks = 0.
  - All port FSMs go to IDLE.
  - Reset mid-handshake aborts it: no ack is issued for a request pending at reset, and an in-flight write is dropped.
- Read port FSM (A and B are identical and independent):
  - States: IDLE, ACKED.
  - IDLE and valid=1 at posedge:
    - Capture mem[addr] into reg_rd_data_x.
    - Assert ack for exactly one cycle.
    - Go to ACKED.
    - Latency: ack is high the cycle after valid is first sampled high.
  - ACKED: ack=0; stay in ACKED while valid=1; go to IDLE when valid=0.
  - A new request requires valid to be low for at least 1 sampled cycle. A valid held high never produces a second ack.
  - reg_rd_data_x holds its value until the next capture. It is never changed outside a capture.
  - Fixed latency guarantee: if A and B valid rise on the same cycle, both acks pulse on the same cycle. The handler's R/B decode depends on this.
  - addr=0 returns 0 regardless of storage.
- Write port FSM:
  - States: IDLE, ACKED.
  - IDLE and reg_wr_valid=1 at posedge:
    - mem[reg_wr_addr] <= reg_wr_data.
    - reg_wr_ack pulses one cycle.
    - Go to ACKED.
  - ACKED: return to IDLE when reg_wr_valid=0.
  - reg_wr_addr=0: storage is unchanged, but ack is still issued.
- Write/read collision:
  - Condition: a read capture and a write commit occur on the same posedge to the same nonzero index.
  - The read returns the new write data (write-first bypass).
  - Different indices do not interact.
  - A and B may read the same index simultaneously; both get the same data.
- No error/overflow conditions exist. Out-of-range addresses are impossible since NUM_REGS = 2**ADDR_WIDTH.

Test Plan:
- Reset then read: deassert reset; raise A valid addr=5 and B valid addr=0 together -> both acks pulse high on the same cycle (next cycle), data_a=0, data_b=0; acks low thereafter while valid held.
- Write then read: write addr=3 data=0xDEADBEEF -> wr_ack pulses once. Then read A addr=3 -> data_a=0xDEADBEEF, one ack pulse.
- x0 protection: write addr=0 data=0xFFFFFFFF -> wr_ack pulses. Then read B addr=0 -> data_b=0.
- Collision bypass: reg 7 holds 0x11; same-cycle write addr=7 data=0x22 and A read addr=7 -> data_a=0x22. A later B read of addr=7 -> 0x22.
- Re-arm rule: hold A valid high 5 cycles with addr=4 -> exactly one ack. Drop valid 1 cycle, raise it with addr=4 -> second ack. data_a is unchanged between captures.
- Reset mid-operation: raise write valid (addr=9, 0x55) and assert reset on that same posedge -> no wr_ack. After release, a read of addr=9 returns 0.
